// File: rtl/dsp_pkg.sv
// Shared constants, state encoding and payload types for the DSP MAC sequencer.
package dsp_pkg;

    localparam int unsigned A_W  = 18;
    localparam int unsigned P_W  = 48;
    localparam int unsigned OP_W = 8;

    // OPMODE codes: X=M/Z=0, X=M/Z=P, X=0/Z=P
    localparam logic [OP_W-1:0] OP_FIRST = 8'h01;
    localparam logic [OP_W-1:0] OP_ACC   = 8'h09;
    localparam logic [OP_W-1:0] OP_HOLD  = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Result payload returned to the consumer
    typedef struct packed {
        logic                  err;
        logic signed [P_W-1:0] p;
    } res_t;

endpackage

// File: rtl/dsp_drain_timer.sv
// Loadable down-counter: done_c pulses for one cycle LAT cycles after load.
module dsp_drain_timer #(
    parameter int unsigned LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done_c
);

    localparam int unsigned CNT_W = $clog2(LAT + 1);

    logic [CNT_W-1:0] cnt;
    logic             busy;

    // Count down from LAT; stop one cycle after reaching zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (load) begin
            cnt  <= CNT_W'(LAT);
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign done_c = busy && (cnt == '0);

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streams signed operand pairs into a DSP slice, sequences OPMODE so P accumulates
// sum(A*B), and returns the 48-bit dot product over valid/ready.
module dsp_mac_sequencer
    import dsp_pkg::*;
#(
    parameter int unsigned MAX_LEN = 256,
    parameter int unsigned DSP_LAT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [A_W-1:0]  in_a,
    input  logic signed [A_W-1:0]  in_b,
    input  logic                   in_last,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic signed [P_W-1:0]  res_p,
    output logic                   res_err,
    output logic signed [A_W-1:0]  dsp_a,
    output logic signed [A_W-1:0]  dsp_b,
    output logic [OP_W-1:0]        dsp_opmode,
    input  logic signed [P_W-1:0]  dsp_p
);

    localparam int unsigned CNT_W = $clog2(MAX_LEN);

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   err, err_nxt;
    logic                   in_ready_nxt;
    logic                   res_valid_nxt;
    res_t                   res_q, res_nxt;
    logic signed [A_W-1:0]  dsp_a_nxt, dsp_b_nxt;
    logic [OP_W-1:0]        dsp_op_nxt;
    logic                   timer_load;
    logic                   drain_done_c;

    // Waits out the slice pipeline after the last operand pair
    dsp_drain_timer #(
        .LAT (DSP_LAT)
    ) u_drain_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .done_c (drain_done_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        err_nxt       = err;
        in_ready_nxt  = 1'b0;
        res_valid_nxt = res_valid;
        res_nxt       = res_q;
        dsp_a_nxt     = dsp_a;
        dsp_b_nxt     = dsp_b;
        dsp_op_nxt    = OP_HOLD;
        timer_load    = 1'b0;

        case (state)
            ST_IDLE: begin
                state_nxt    = ST_LOAD;
                in_ready_nxt = 1'b1;
            end
            ST_LOAD: begin
                in_ready_nxt = 1'b1;
                if (in_valid && in_ready) begin
                    dsp_a_nxt  = in_a;
                    dsp_b_nxt  = in_b;
                    dsp_op_nxt = (cnt == '0) ? OP_FIRST : OP_ACC;
                    cnt_nxt    = cnt + CNT_W'(1);
                    // Vector ends on IN_LAST or when the length limit is hit
                    if (in_last || (cnt == CNT_W'(MAX_LEN - 1))) begin
                        state_nxt    = ST_DRAIN;
                        in_ready_nxt = 1'b0;
                        timer_load   = 1'b1;
                        if (!in_last) begin
                            err_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_done_c) begin
                    state_nxt     = ST_DONE;
                    res_valid_nxt = 1'b1;
                    res_nxt.p     = dsp_p;
                    res_nxt.err   = err;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_nxt     = ST_LOAD;
                    in_ready_nxt  = 1'b1;
                    res_valid_nxt = 1'b0;
                    cnt_nxt       = '0;
                    err_nxt       = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            err        <= 1'b0;
            in_ready   <= 1'b0;
            res_valid  <= 1'b0;
            res_q      <= '0;
            dsp_a      <= '0;
            dsp_b      <= '0;
            dsp_opmode <= OP_HOLD;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            err        <= err_nxt;
            in_ready   <= in_ready_nxt;
            res_valid  <= res_valid_nxt;
            res_q      <= res_nxt;
            dsp_a      <= dsp_a_nxt;
            dsp_b      <= dsp_b_nxt;
            dsp_opmode <= dsp_op_nxt;
        end
    end

    assign res_p   = res_q.p;
    assign res_err = res_q.err;

endmodule
